// File: rtl/regs_writer.sv
// Register-file write-port front end: arbitrates load, ALU and buffered divider
// results onto one registered write port, aligning load data on the way.
module regs_writer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_waddr,
  input  logic [DATA_W-1:0]        alu_wdata,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_waddr,
  input  logic [DATA_W-1:0]        ld_rdata,
  input  logic [1:0]               ld_off,
  input  logic [1:0]               ld_size,
  input  logic                     ld_sext,
  output logic                     ld_ready,
  input  logic                     div_valid,
  input  logic [ADDR_W-1:0]        div_waddr,
  input  logic [DATA_W-1:0]        div_wdata,
  output logic                     div_ready,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     err_misalign
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {SRC_NONE, SRC_LD, SRC_ALU, SRC_DIV} src_e;

  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] rdata,
                                                   input logic [1:0]        off,
                                                   input logic [1:0]        size,
                                                   input logic              sext);
    logic [DATA_W-1:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'd0:    return {{(DATA_W-8){sext & lane[7]}}, lane[7:0]};
      2'd1:    return {{(DATA_W-16){sext & lane[15]}}, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      default: return off != 2'd0;
    endcase
  endfunction

  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 err_q, err_d;

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [FIFO_DEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0]    slot_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    slot_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0]    slot_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]    slot_data_d [FIFO_DEPTH];

  logic full, empty, push, pop;
  src_e src;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign div_ready = !full;
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign push      = div_valid && !full;

  // A full FIFO forces the head through so divider results cannot starve.
  always_comb begin
    src = SRC_NONE;
    if (full)           src = SRC_DIV;
    else if (ld_valid)  src = SRC_LD;
    else if (alu_valid) src = SRC_ALU;
    else if (!empty)    src = SRC_DIV;
  end

  assign pop = (src == SRC_DIV);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (src)
      SRC_LD: begin
        if (load_misaligned(ld_off, ld_size)) begin
          err_d = 1'b1;
        end else if (ld_waddr != '0) begin
          we_d    = 1'b1;
          waddr_d = ld_waddr;
          wdata_d = align_load(ld_rdata, ld_off, ld_size, ld_sext);
        end
      end
      SRC_ALU: begin
        if (alu_waddr != '0) begin
          we_d    = 1'b1;
          waddr_d = alu_waddr;
          wdata_d = alu_wdata;
        end
      end
      SRC_DIV: begin
        if (slot_addr_q[rd_ptr_q] != '0) begin
          we_d    = 1'b1;
          waddr_d = slot_addr_q[rd_ptr_q];
          wdata_d = slot_data_q[rd_ptr_q];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    if (pop) begin
      slot_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      slot_vld_d[wr_ptr_q]  = 1'b1;
      slot_addr_d[wr_ptr_q] = div_waddr;
      slot_data_d[wr_ptr_q] = div_wdata;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Register 0 is never written, so it never shows as pending.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld_q[i]) pending[slot_addr_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      slot_vld_q <= '0;
    end else begin
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_addr_q <= slot_addr_d;
    slot_data_q <= slot_data_d;
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign err_misalign = err_q;

endmodule
